inv_cipher_seq: RTL and testbench

//  Iterative AES inverse cipher (FIPS-197 InvCipher): one round per clock, valid/ready on both sides.

---
 rtl/aes_pkg.sv | 111 +++++++++++
 rtl/inv_round.sv | 19 +
 rtl/keyexpansion.sv | 37 +++
 rtl/inv_cipher_seq.sv | 144 ++++++++++++++
 tb/tb_inv_cipher_seq.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: state layout, FSM encoding and byte-level GF(2^8) helpers.
// State layout: bit 127 is the MSB of byte 0; byte 4c+r holds row r of column c.
package aes_pkg;

  localparam int AES_STATE_W = 128;

  typedef logic [AES_STATE_W-1:0] state_t;
  typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} fsm_t;

  function automatic int nr_for_nk(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtimes(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] acc;
    p = a;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtimes(p);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] b);
    return xtimes(xtimes(xtimes(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
    return xtimes(xtimes(xtimes(b))) ^ xtimes(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
    return xtimes(xtimes(xtimes(b))) ^ xtimes(xtimes(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
    return xtimes(xtimes(xtimes(b))) ^ xtimes(xtimes(b)) ^ xtimes(b);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Row r rotates right by r columns.
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r)&3)+r) -: 8];
    return o;
  endfunction

  function automatic state_t inv_sub_bytes(input state_t s);
    state_t o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3);
      o[119-32*c -: 8] = gf_mul09(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3);
      o[111-32*c -: 8] = gf_mul0d(a0) ^ gf_mul09(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3);
      o[103-32*c -: 8] = gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2) ^ gf_mul0e(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_round.sv
// One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module inv_round
  import aes_pkg::*;
(
  input  state_t st,
  input  state_t rk,
  input  logic   last,
  output state_t nxt
);

  state_t ark;

  // The final round (key 0) has no InvMixColumns.
  always_comb begin
    ark = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
    nxt = last ? ark : inv_mix_columns(ark);
  end

endmodule

// File: rtl/keyexpansion.sv
// Combinational AES key schedule: all Nr+1 round keys, word 0 in the top 32 bits of w.
module keyexpansion
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic [Nk*32-1:0]      key,
  output logic [128*(Nr+1)-1:0] w
);

  localparam int NW = 4 * (Nr + 1);

  logic [31:0] wd [NW];
  logic [31:0] t;
  logic [7:0]  rc;

  // Expand the cipher key word by word; rcon advances on every Nk-th word.
  always_comb begin
    rc = 8'h01;
    t  = '0;
    w  = '0;
    for (int i = 0; i < Nk; i++) wd[i] = key[Nk*32-1-32*i -: 32];
    for (int i = Nk; i < NW; i++) begin
      t = wd[i-1];
      if (i % Nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtimes(rc);
      end else if (Nk > 6 && i % Nk == 4) begin
        t = sub_word(t);
      end
      wd[i] = wd[i-Nk] ^ t;
    end
    for (int i = 0; i < NW; i++) w[128*(Nr+1)-1-32*i -: 32] = wd[i];
  end

endmodule

// File: rtl/inv_cipher_seq.sv
// Iterative AES inverse cipher, one round per clock, valid/ready on input and output.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid must then hold its payload until that edge, ready never depends on valid.
// Optional trace: define INV_CIPHER_TRACE_EN to print per-round sub-steps in simulation.
module inv_cipher_seq
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10,
  localparam int Nkb = Nk * 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   ct,
  input  logic [Nkb-1:0] key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   pt
);

  localparam int RW = $clog2(Nr + 1);
  localparam int WW = 128 * (Nr + 1);

  if (Nr != nr_for_nk(Nk)) begin : g_nr_check
    $error("inv_cipher_seq: Nr does not match Nk");
  end

  fsm_t           state_q, state_d;
  state_t         st_q, st_d;
  state_t         pt_q, pt_d;
  logic [Nkb-1:0] key_q, key_d;
  logic [RW-1:0]  rnd_q, rnd_d;
  logic           out_valid_q, out_valid_d;
  logic           rdy_en_q, rdy_en_d;

  logic [Nkb-1:0] ks_key;
  logic [WW-1:0]  w;
  logic [RW-1:0]  rk_idx;
  state_t         rk;
  state_t         round_out;
  logic           is_last;

  // One schedule instance: live key on the accept edge, stored key while iterating.
  always_comb begin
    ks_key  = (state_q == IDLE) ? key : key_q;
    rk_idx  = (state_q == IDLE) ? RW'(Nr) : rnd_q;
    rk      = w[WW-1-128*int'(rk_idx) -: 128];
    is_last = (state_q == LAST);
  end

  keyexpansion #(.Nk(Nk), .Nr(Nr)) u_keyexp (
    .key (ks_key),
    .w   (w)
  );

  inv_round u_round (
    .st   (st_q),
    .rk   (rk),
    .last (is_last),
    .nxt  (round_out)
  );

  // Next-state and datapath updates; everything holds by default.
  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    pt_d        = pt_q;
    key_d       = key_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    rdy_en_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          key_d   = key;
          st_d    = ct ^ rk;
          rnd_d   = RW'(Nr - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        st_d  = round_out;
        rnd_d = rnd_q - RW'(1);
        if (rnd_q == RW'(1)) state_d = LAST;
      end
      LAST: begin
        pt_d        = round_out;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      st_q        <= '0;
      pt_q        <= '0;
      key_q       <= '0;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      pt_q        <= pt_d;
      key_q       <= key_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  // rdy_en_q keeps in_ready low until the first clock after reset release.
  assign in_ready  = rdy_en_q && (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign pt        = pt_q;

`ifdef INV_CIPHER_TRACE_EN
  // Print the round key and each sub-step of the round applied at this edge.
  always @(posedge clk) begin
    if (rst_n && (state_q == RUN || state_q == LAST)) begin
      $display("Round %0d", rnd_q);
      $display("  round key     %h", rk);
      $display("  InvShiftRows  %h", inv_shift_rows(st_q));
      $display("  InvSubBytes   %h", inv_sub_bytes(inv_shift_rows(st_q)));
      $display("  AddRoundKey   %h", inv_sub_bytes(inv_shift_rows(st_q)) ^ rk);
      if (state_q == RUN)
        $display("  InvMixColumns %h", round_out);
    end
  end
`endif

endmodule

// File: tb/tb_inv_cipher_seq.sv
// Bench for inv_cipher_seq: FIPS-197 vectors for AES-128/192/256, backpressure,
// reset mid-run and a randomly gapped stream with an in-order scoreboard.
module tb_inv_cipher_seq;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT signals ----------------
  logic         in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [127:0] ct = '0, key = '0, pt;
  logic         v6_in_valid = 0, v6_in_ready, v6_out_valid, v6_out_ready = 0;
  logic [127:0] v6_ct = '0, v6_pt;
  logic [191:0] v6_key = '0;
  logic         v8_in_valid = 0, v8_in_ready, v8_out_valid, v8_out_ready = 0;
  logic [127:0] v8_ct = '0, v8_pt;
  logic [255:0] v8_key = '0;

  inv_cipher_seq #(.Nk(4), .Nr(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ct(ct), .key(key),
    .out_valid(out_valid), .out_ready(out_ready), .pt(pt));

  inv_cipher_seq #(.Nk(6), .Nr(12)) dut192 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6_in_valid), .in_ready(v6_in_ready), .ct(v6_ct),
    .key(v6_key), .out_valid(v6_out_valid), .out_ready(v6_out_ready), .pt(v6_pt));

  inv_cipher_seq #(.Nk(8), .Nr(14)) dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8_in_valid), .in_ready(v8_in_ready), .ct(v8_ct),
    .key(v8_key), .out_valid(v8_out_valid), .out_ready(v8_out_ready), .pt(v8_pt));

  // ---------------- vectors ----------------
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  logic [127:0] exp_q[$];

  // ---------------- driver tasks ----------------
  // Present one AES-128 block, check latency and result, then complete the handshake.
  task automatic decrypt128(input string name, input logic [127:0] k, input logic [127:0] c,
                            input logic [127:0] exp);
    int n;
    bit seen;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_idle_ready: got %b want 1", name, in_ready); end
    in_valid = 1; key = k; ct = c; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    key = {$urandom, $urandom, $urandom, $urandom};
    ct  = {$urandom, $urandom, $urandom, $urandom};
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_busy_ready: got %b want 0", name, in_ready); end
    n = 0; seen = 0;
    while (!seen && n < 40) begin @(posedge clk); #1; n++; if (out_valid === 1'b1) seen = 1; end
    checks++;
    if (!seen || n != 10) begin errors++; $display("FAIL %s_latency: got %0d want 10", name, n); end
    checks++;
    if (pt !== exp) begin errors++; $display("FAIL %s_pt: got %h want %h", name, pt, exp); end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_handshake: out_valid got %b want 0", name, out_valid); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (pt !== 128'h0) begin errors++; $display("FAIL reset_pt: got %h want 0", pt); end
    rst_n = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (v6_in_ready !== 1'b1 || v8_in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_wide_ready: got %b%b want 11", v6_in_ready, v8_in_ready);
    end
  endtask

  task automatic test_fips_vectors();
    decrypt128("fips_b", KEY_B, CT_B, PT_B);
    decrypt128("c1_aes128", KEY_C, CT_C, PT_C);
  endtask

  task automatic test_aes192();
    int n;
    bit seen;
    v6_in_valid = 1; v6_ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    v6_key = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    @(posedge clk); #1;
    v6_in_valid = 0; v6_ct = '0; v6_key = '0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin @(posedge clk); #1; n++; if (v6_out_valid === 1'b1) seen = 1; end
    checks++;
    if (!seen || n != 12) begin errors++; $display("FAIL c2_latency: got %0d want 12", n); end
    checks++;
    if (v6_pt !== PT_C) begin errors++; $display("FAIL c2_pt: got %h want %h", v6_pt, PT_C); end
    v6_out_ready = 1; @(posedge clk); #1; v6_out_ready = 0;
  endtask

  task automatic test_aes256();
    int n;
    bit seen;
    v8_in_valid = 1; v8_ct = 128'h8ea2b7ca516745bfeafc49904b496089;
    v8_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    @(posedge clk); #1;
    v8_in_valid = 0; v8_ct = '0; v8_key = '0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin @(posedge clk); #1; n++; if (v8_out_valid === 1'b1) seen = 1; end
    checks++;
    if (!seen || n != 14) begin errors++; $display("FAIL c3_latency: got %0d want 14", n); end
    checks++;
    if (v8_pt !== PT_C) begin errors++; $display("FAIL c3_pt: got %h want %h", v8_pt, PT_C); end
    v8_out_ready = 1; @(posedge clk); #1; v8_out_ready = 0;
  endtask

  // Stall the sink; a second block held at the input must wait, then go through intact.
  task automatic test_backpressure();
    int n;
    bit seen;
    bit bad;
    out_ready = 1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_ready: out_valid got %b want 0", out_valid); end
    out_ready = 0;
    in_valid = 1; key = KEY_C; ct = CT_C;
    @(posedge clk); #1;
    key = KEY_B; ct = CT_B;            // next block waits at the input
    n = 0; seen = 0;
    while (!seen && n < 40) begin @(posedge clk); #1; n++; if (out_valid === 1'b1) seen = 1; end
    checks++;
    if (!seen || pt !== PT_C) begin errors++; $display("FAIL bp_first_pt: got %h want %h", pt, PT_C); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bad = (out_valid !== 1'b1) || (pt !== PT_C) || (in_ready !== 1'b0);
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b ready=%b pt=%h want 1 0 %h", i, out_valid, in_ready, pt, PT_C);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;                 // held block accepted here
    in_valid = 0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin @(posedge clk); #1; n++; if (out_valid === 1'b1) seen = 1; end
    checks++;
    if (!seen || n != 10 || pt !== PT_B) begin
      errors++; $display("FAIL bp_held_block: got pt=%h after %0d want %h after 10", pt, n, PT_B);
    end
    out_ready = 1; @(posedge clk); #1; out_ready = 0;
  endtask

  task automatic test_reset_mid_run();
    in_valid = 1; key = KEY_B; ct = CT_B;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) begin @(posedge clk); #1; end
    #1 rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || pt !== 128'h0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL abort: got valid=%b ready=%b pt=%h want 0 0 0", out_valid, in_ready, pt);
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", in_ready); end
    decrypt128("after_abort", KEY_C, CT_C, PT_C);
  endtask

  // Gapped source and random sink; results must come back in order.
  task automatic test_back_to_back();
    localparam int N = 24;
    int got;
    int n;
    logic [127:0] e;
    fork
      begin
        bit acc;
        int w;
        for (int b = 0; b < N; b++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          if ($urandom_range(0, 1) == 1) begin key = KEY_B; ct = CT_B; exp_q.push_back(PT_B); end
          else begin key = KEY_C; ct = CT_C; exp_q.push_back(PT_C); end
          in_valid = 1;
          acc = 0; w = 0;
          while (!acc && w < 100) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; w++;
          end
          in_valid = 0;
          ct = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      begin
        got = 0; n = 0;
        while (got < N && n < 3000) begin
          @(negedge clk);
          if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL stream_extra: got %h want no output", pt);
            end else begin
              e = exp_q.pop_front();
              if (pt !== e) begin errors++; $display("FAIL stream_%0d: got %h want %h", got, pt, e); end
            end
            got++;
          end
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 1) == 1);
          n++;
        end
        out_ready = 0;
        checks++;
        if (got != N) begin errors++; $display("FAIL stream_count: got %0d want %0d", got, N); end
      end
    join
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stream_leftover: got %0d want 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fips_vectors();
    test_aes192();
    test_aes256();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
